// File: rtl/oh_idx_encoder_pipe.sv
// Registered priority / round-robin index encoder with a valid/ready handshake.
// Picks one set bit of the request vector, reports its index (LSB0 or MSB0
// numbering), a zero flag, a multi-hot flag and the population count.
// The output stage holds a single entry.
module oh_idx_encoder_pipe #(
   parameter int    NUM_SIGNALS = 8,
   parameter string DIRECTION   = "LSB0",
   parameter string MODE        = "FIXED",
   parameter int    INDEX_WIDTH = $clog2(NUM_SIGNALS),
   parameter int    COUNT_WIDTH = $clog2(NUM_SIGNALS + 1)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NUM_SIGNALS-1:0] in_vector,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INDEX_WIDTH-1:0] out_index,
   output logic                   out_zero,
   output logic                   out_multi_hot,
   output logic [COUNT_WIDTH-1:0] out_count
);

   localparam bit IS_RR   = (MODE == "RR");
   localparam bit IS_MSB0 = (DIRECTION == "MSB0");
   localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUM_SIGNALS - 1);

   // Catch bad configurations at elaboration time.
   if (NUM_SIGNALS < 2) begin : g_bad_width
      $error("oh_idx_encoder_pipe: NUM_SIGNALS must be >= 2");
   end
   if (!(MODE == "FIXED" || MODE == "RR")) begin : g_bad_mode
      $error("oh_idx_encoder_pipe: MODE must be \"FIXED\" or \"RR\"");
   end
   if (!(DIRECTION == "LSB0" || DIRECTION == "MSB0")) begin : g_bad_dir
      $error("oh_idx_encoder_pipe: DIRECTION must be \"LSB0\" or \"MSB0\"");
   end

   logic                   out_valid_q, out_valid_d;
   logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;
   logic                   out_zero_q, out_zero_d;
   logic                   out_multi_q, out_multi_d;
   logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
   logic [INDEX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

   logic                   accept;
   logic                   any_set;
   logic                   found;
   logic [INDEX_WIDTH-1:0] sel_p;
   logic [INDEX_WIDTH-1:0] sel_idx;
   logic [COUNT_WIDTH-1:0] pop;
   int                     j;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Physical position of the winning bit, its reported index and the popcount.
   always_comb begin
      found   = 1'b0;
      sel_p   = '0;
      sel_idx = '0;
      pop     = '0;
      j       = 0;
      any_set = |in_vector;
      if (IS_RR) begin
         // Scan upward from the pointer, wrapping at the top.
         for (int k = 0; k < NUM_SIGNALS; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_SIGNALS) j = j - NUM_SIGNALS;
            if (!found && in_vector[j]) begin
               found = 1'b1;
               sel_p = j[INDEX_WIDTH-1:0];
            end
         end
      end else if (IS_MSB0) begin
         // MSB0 priority means the highest physical position wins.
         for (int i = NUM_SIGNALS - 1; i >= 0; i--) begin
            if (!found && in_vector[i]) begin
               found = 1'b1;
               sel_p = i[INDEX_WIDTH-1:0];
            end
         end
      end else begin
         for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (!found && in_vector[i]) begin
               found = 1'b1;
               sel_p = i[INDEX_WIDTH-1:0];
            end
         end
      end
      // Subtract rather than invert so non-power-of-2 widths map correctly.
      if (any_set) sel_idx = IS_MSB0 ? (LAST - sel_p) : sel_p;
      for (int i = 0; i < NUM_SIGNALS; i++) begin
         pop = pop + COUNT_WIDTH'(in_vector[i]);
      end
   end

   // Next state of the output entry and the round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_index_d = out_index_q;
      out_zero_d  = out_zero_q;
      out_multi_d = out_multi_q;
      out_count_d = out_count_q;
      rr_ptr_d    = rr_ptr_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_index_d = sel_idx;
         out_zero_d  = !any_set;
         out_multi_d = (pop >= COUNT_WIDTH'(2));
         out_count_d = pop;
         // A zero vector leaves the pointer where it was.
         if (IS_RR && any_set) rr_ptr_d = (sel_p == LAST) ? '0 : sel_p + INDEX_WIDTH'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset drops any held result immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_index_q <= '0;
         out_zero_q  <= 1'b0;
         out_multi_q <= 1'b0;
         out_count_q <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_index_q <= out_index_d;
         out_zero_q  <= out_zero_d;
         out_multi_q <= out_multi_d;
         out_count_q <= out_count_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_index     = out_index_q;
   assign out_zero      = out_zero_q;
   assign out_multi_hot = out_multi_q;
   assign out_count     = out_count_q;

endmodule

// File: tb/tb_oh_idx_encoder_pipe.sv
// Bench for oh_idx_encoder_pipe: ten configurations share one stimulus stream
// (handshake timing does not depend on data, so they stay in lockstep) and are
// compared against a behavioural selection model.
module tb_oh_idx_encoder_pipe;

   localparam int NI = 10;
   localparam int NS [NI] = '{8, 8, 8, 8, 7, 7, 7, 7, 6, 4};
   localparam bit MS [NI] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0};
   localparam bit RR [NI] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1};

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] in_vector;

   logic       o_rdy [NI];
   logic       o_vld [NI];
   logic [3:0] o_idx [NI];
   logic       o_zero [NI];
   logic       o_multi [NI];
   logic [3:0] o_cnt [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int N = NS[g];
      logic [$clog2(N)-1:0]   idx;
      logic [$clog2(N+1)-1:0] cnt;
      if (RR[g]) begin : g_rr
         oh_idx_encoder_pipe #(.NUM_SIGNALS(N), .DIRECTION(MS[g] ? "MSB0" : "LSB0"), .MODE("RR")) u_dut (
            .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(o_rdy[g]),
            .in_vector(in_vector[N-1:0]), .out_valid(o_vld[g]), .out_ready(out_ready),
            .out_index(idx), .out_zero(o_zero[g]), .out_multi_hot(o_multi[g]), .out_count(cnt));
      end else begin : g_fx
         oh_idx_encoder_pipe #(.NUM_SIGNALS(N), .DIRECTION(MS[g] ? "MSB0" : "LSB0"), .MODE("FIXED")) u_dut (
            .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(o_rdy[g]),
            .in_vector(in_vector[N-1:0]), .out_valid(o_vld[g]), .out_ready(out_ready),
            .out_index(idx), .out_zero(o_zero[g]), .out_multi_hot(o_multi[g]), .out_count(cnt));
      end
      assign o_idx[g] = 4'(idx);
      assign o_cnt[g] = 4'(cnt);
   end

   int total = 0;
   int bad   = 0;

   // Reference state: one expected entry per configuration plus its pointer.
   bit m_v;
   int m_idx [NI];
   int m_cnt [NI];
   int m_ptr [NI];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Selection from the rules: count bits, then find the winner by plain scanning.
   function automatic void ref_sel(input int n, input bit msb0, input bit rr, input int ptr,
                                   input logic [7:0] vec, output int idx, output int cnt,
                                   output int nptr);
      int p;
      p    = -1;
      cnt  = 0;
      nptr = ptr;
      idx  = 0;
      for (int i = 0; i < n; i++) if (vec[i]) cnt++;
      if (cnt != 0) begin
         if (rr) begin
            for (int k = 0; k < n; k++) if (p < 0 && vec[(ptr + k) % n]) p = (ptr + k) % n;
            nptr = (p + 1) % n;
         end else if (msb0) begin
            for (int i = n - 1; i >= 0; i--) if (p < 0 && vec[i]) p = i;
         end else begin
            for (int i = 0; i < n; i++) if (p < 0 && vec[i]) p = i;
         end
         idx = msb0 ? (n - 1 - p) : p;
      end
   endfunction

   task automatic model_reset();
      m_v = 1'b0;
      for (int g = 0; g < NI; g++) begin
         m_idx[g] = 0; m_cnt[g] = 0; m_ptr[g] = 0;
      end
   endtask

   task automatic check_outs();
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("out_valid[%0d]", g), 32'(o_vld[g]), 32'(m_v));
         if (m_v) begin
            chk($sformatf("out_index[%0d]", g), 32'(o_idx[g]), m_idx[g]);
            chk($sformatf("out_count[%0d]", g), 32'(o_cnt[g]), m_cnt[g]);
            chk($sformatf("out_zero[%0d]", g), 32'(o_zero[g]), 32'(m_cnt[g] == 0));
            chk($sformatf("out_multi[%0d]", g), 32'(o_multi[g]), 32'(m_cnt[g] >= 2));
         end
      end
   endtask

   task automatic check_reset_vals();
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("rst_valid[%0d]", g), 32'(o_vld[g]), 0);
         chk($sformatf("rst_index[%0d]", g), 32'(o_idx[g]), 0);
         chk($sformatf("rst_zero[%0d]", g), 32'(o_zero[g]), 0);
         chk($sformatf("rst_multi[%0d]", g), 32'(o_multi[g]), 0);
         chk($sformatf("rst_count[%0d]", g), 32'(o_cnt[g]), 0);
      end
   endtask

   // One cycle starting at a falling edge: drive, check in_ready, advance, check outputs.
   task automatic cyc(input bit v, input logic [7:0] vec, input bit rdy);
      bit acc;
      in_valid  = v;
      in_vector = vec;
      out_ready = rdy;
      #1;
      acc = v && (!m_v || rdy);
      for (int g = 0; g < NI; g++)
         chk($sformatf("in_ready[%0d]", g), 32'(o_rdy[g]), 32'(!m_v || rdy));
      @(posedge clk);
      if (acc) begin
         m_v = 1'b1;
         for (int g = 0; g < NI; g++)
            ref_sel(NS[g], MS[g], RR[g], m_ptr[g], vec, m_idx[g], m_cnt[g], m_ptr[g]);
      end else if (rdy) begin
         m_v = 1'b0;
      end
      @(negedge clk);
      check_outs();
   endtask

   initial begin
      logic [7:0] vec;
      int         kind;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_vector = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_vals();
      reset_n = 1'b1;

      // N=4 RR: pointer walk and wrap, then a zero vector leaves the pointer alone.
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 8'h0F, 1'b1);
         chk("rr_walk", 32'(o_idx[9]), i % 4);
      end
      cyc(1'b1, 8'h00, 1'b1);
      chk("rr_zero_flag", 32'(o_zero[9]), 1);
      chk("rr_zero_idx", 32'(o_idx[9]), 0);
      cyc(1'b1, 8'h0F, 1'b1);
      chk("rr_after_zero", 32'(o_idx[9]), 1);

      // Backpressure: three stalled cycles with in_valid held, then release.
      cyc(1'b1, 8'h0F, 1'b1);
      chk("bp_first", 32'(o_idx[9]), 2);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 8'h0F, 1'b0);
         chk("bp_in_ready", 32'(o_rdy[9]), 0);
         chk("bp_hold_idx", 32'(o_idx[9]), 2);
         chk("bp_hold_vld", 32'(o_vld[9]), 1);
      end
      cyc(1'b1, 8'h0F, 1'b1);
      chk("bp_rel_1", 32'(o_idx[9]), 3);
      cyc(1'b1, 8'h0F, 1'b1);
      chk("bp_rel_2", 32'(o_idx[9]), 0);

      // Fixed-priority examples.
      cyc(1'b1, 8'h10, 1'b1);
      chk("fx_lsb0_idx", 32'(o_idx[0]), 4);
      chk("fx_lsb0_cnt", 32'(o_cnt[0]), 1);
      chk("fx_lsb0_multi", 32'(o_multi[0]), 0);
      cyc(1'b1, 8'h24, 1'b1);
      chk("fx_msb0_idx", 32'(o_idx[1]), 2);
      chk("fx_msb0_multi", 32'(o_multi[1]), 1);
      chk("fx_msb0_cnt", 32'(o_cnt[1]), 2);
      cyc(1'b1, 8'h01, 1'b1);
      chk("n6_msb0_idx", 32'(o_idx[8]), 5);
      cyc(1'b1, 8'hFF, 1'b1);
      chk("full_cnt_n8", 32'(o_cnt[0]), 8);
      chk("full_cnt_n7", 32'(o_cnt[4]), 7);

      // Asynchronous reset while a result is held in RR with pointer at 2.
      cyc(1'b1, 8'h02, 1'b1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      for (int g = 0; g < NI; g++) chk($sformatf("async_rst_vld[%0d]", g), 32'(o_vld[g]), 0);
      model_reset();
      @(negedge clk);
      check_reset_vals();
      reset_n = 1'b1;
      cyc(1'b1, 8'h06, 1'b1);
      chk("rst_ptr_cleared", 32'(o_idx[9]), 1);

      // Random traffic with random valid/ready across all configurations.
      for (int c = 0; c < 12000; c++) begin
         kind = int'($urandom_range(0, 3));
         case (kind)
            0:       vec = 8'($urandom);
            1:       vec = 8'h00;
            2:       vec = 8'(1) << $urandom_range(0, 7);
            default: vec = 8'hFF;
         endcase
         cyc($urandom_range(0, 3) != 0, vec, $urandom_range(0, 2) != 0);
      end
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
